// File: rtl/pong_game_ctrl.sv
// Pong game sequencer. Once per frame it checks the ball against the walls and
// paddles. It updates the motion vector, pulses ball_step or ball_load, and
// tracks the score, the serve direction and game-over.
module pong_game_ctrl #(
  parameter int V_RES        = 480,
  parameter int PADDLE_X_L   = 4,
  parameter int PADDLE_X_R   = 635,
  parameter int PADDLE_H     = 48,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              start,
  input  logic [9:0]        ball_x,
  input  logic [9:0]        ball_y,
  input  logic [9:0]        pad_l_y,
  input  logic [9:0]        pad_r_y,
  output logic signed [3:0] vect_x,
  output logic signed [3:0] vect_y,
  output logic              ball_step,
  output logic              ball_load,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic              game_over
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SERVE     = 2'd1;
  localparam logic [1:0] S_PLAY      = 2'd2;
  localparam logic [1:0] S_GAME_OVER = 2'd3;

  localparam logic signed [3:0] V_POS = 4'(BALL_SPEED);
  localparam logic signed [3:0] V_NEG = 4'(-BALL_SPEED);

  // All position arithmetic is 11 bits wide, so that pad_y + PADDLE_H - 1 cannot wrap.
  localparam logic [10:0] TOP_LIM = 11'(BALL_SPEED);
  localparam logic [10:0] BOT_LIM = 11'(V_RES - 1 - BALL_SPEED);
  localparam logic [10:0] LX_LO   = 11'(PADDLE_X_L);
  localparam logic [10:0] LX_HI   = 11'(PADDLE_X_L + BALL_SPEED);
  localparam logic [10:0] RX_LO   = 11'(PADDLE_X_R - BALL_SPEED);
  localparam logic [10:0] RX_HI   = 11'(PADDLE_X_R);
  localparam logic [10:0] PH_M1   = 11'(PADDLE_H - 1);
  localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
  localparam logic [7:0]  SRV_END = 8'(SERVE_FRAMES - 1);

  logic [1:0]        state_q, state_d;
  logic              vs_d_q, vs_d_d;
  logic signed [3:0] vect_x_q, vect_x_d, vect_y_q, vect_y_d;
  logic              step_q, step_d, load_q, load_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic              serve_left_q, serve_left_d;  // 1: serve toward the left (-x)
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic        frame_tick;
  logic [10:0] bx, by, pl, pr;
  logic        vx_neg, vx_pos, vy_neg, vy_pos;
  logic        hit_top, hit_bot, hit_l, hit_r, miss_l, miss_r;

  assign frame_tick = vs_d_q & ~vsync;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pl = {1'b0, pad_l_y};
  assign pr = {1'b0, pad_r_y};

  assign vx_neg = vect_x_q[3];
  assign vx_pos = !vect_x_q[3] && (vect_x_q != 4'sd0);
  assign vy_neg = vect_y_q[3];
  assign vy_pos = !vect_y_q[3] && (vect_y_q != 4'sd0);

  // Evaluate the wall and paddle checks in parallel on the sampled position.
  always_comb begin
    hit_top = vy_neg && (by <= TOP_LIM);
    hit_bot = vy_pos && (by >= BOT_LIM);
    hit_l   = vx_neg && (bx >= LX_LO) && (bx <= LX_HI) && (by >= pl) && (by <= pl + PH_M1);
    hit_r   = vx_pos && (bx >= RX_LO) && (bx <= RX_HI) && (by >= pr) && (by <= pr + PH_M1);
    miss_l  = vx_neg && (bx < LX_LO) && !hit_l;
    miss_r  = vx_pos && (bx > RX_HI) && !hit_r;
  end

  // Compute the next state: sequencing, vector updates, scoring and output pulses.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    vs_d_d       = vsync;
    vect_x_d     = vect_x_q;
    vect_y_d     = vect_y_q;
    step_d       = 1'b0;
    load_d       = 1'b0;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_left_d = serve_left_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          score_l_d    = 4'd0;
          score_r_d    = 4'd0;
          serve_left_d = 1'b0;
          state_d      = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (frame_cnt_q == SRV_END) state_d = S_PLAY;
          else frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          if (miss_l) begin
            score_r_d    = (score_r_q == 4'hF) ? score_r_q : score_r_q + 4'd1;
            serve_left_d = 1'b1;
            state_d      = (score_r_d == WIN) ? S_GAME_OVER : S_SERVE;
          end else if (miss_r) begin
            score_l_d    = (score_l_q == 4'hF) ? score_l_q : score_l_q + 4'd1;
            serve_left_d = 1'b0;
            state_d      = (score_l_d == WIN) ? S_GAME_OVER : S_SERVE;
          end else begin
            if (hit_top) vect_y_d = V_POS;
            if (hit_bot) vect_y_d = V_NEG;
            if (hit_l)   vect_x_d = V_POS;
            if (hit_r)   vect_x_d = V_NEG;
            step_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // On entry to SERVE, recentre the ball and aim it along the serve direction.
    if (state_d == S_SERVE && state_q != S_SERVE) begin
      load_d      = 1'b1;
      frame_cnt_d = 8'd0;
      vect_x_d    = serve_left_d ? V_NEG : V_POS;
      vect_y_d    = V_POS;
    end
  end

  // Register all state. The reset is synchronous and active-high.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      vs_d_q       <= 1'b1;
      vect_x_q     <= V_POS;
      vect_y_q     <= V_POS;
      step_q       <= 1'b0;
      load_q       <= 1'b0;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
      serve_left_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      vs_d_q       <= vs_d_d;
      vect_x_q     <= vect_x_d;
      vect_y_q     <= vect_y_d;
      step_q       <= step_d;
      load_q       <= load_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      serve_left_q <= serve_left_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign vect_x    = vect_x_q;
  assign vect_y    = vect_y_q;
  assign ball_step = step_q;
  assign ball_load = load_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = (state_q == S_GAME_OVER);

endmodule
